// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result, remainder and status flags.
// Define ALU_MULDIV_EN to build the iterative shift-add multiplier and restoring divider.
module seq_alu #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             flag_dz,
    output logic             flag_illegal
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010,
                           OP_DIV = 4'b0011, OP_SHL = 4'b0100, OP_SHR = 4'b0101,
                           OP_ROL = 4'b0110, OP_ROR = 4'b0111, OP_AND = 4'b1000,
                           OP_OR  = 4'b1001, OP_XOR = 4'b1010, OP_NOR = 4'b1011,
                           OP_NAND = 4'b1100, OP_XNOR = 4'b1101, OP_GT = 4'b1110,
                           OP_EQ  = 4'b1111;

    state_t           state, state_next;
    logic             accept, iter_req, launch, load_out;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] sc_result, sc_rem, fin_result, fin_rem;
    logic             sc_carry, sc_dz, sc_illegal;
    logic             fin_carry, fin_ovf, fin_dz, fin_illegal;

    // launch marks a latched single-cycle op waiting one cycle to be evaluated
    assign in_ready  = (state == IDLE) && !launch && !reset;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

`ifdef ALU_MULDIV_EN
    // work_hi/work_lo hold the product accumulator (MUL) or remainder/quotient (DIV)
    logic [WIDTH:0]   work_hi, mul_sum, div_shift;
    logic [WIDTH+1:0] div_trial;
    logic [WIDTH-1:0] work_lo, work_b;
    logic [CNT_W-1:0] cnt;
    logic             is_mul;

    assign iter_req  = (opcode == OP_MUL) || ((opcode == OP_DIV) && (operand2 != '0));
    assign mul_sum   = work_hi + {1'b0, (work_lo[0] ? work_b : '0)};
    assign div_shift = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
    assign div_trial = {1'b0, div_shift} - {2'b00, work_b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_hi <= '0;
            work_lo <= '0;
            work_b  <= '0;
            cnt     <= '0;
            is_mul  <= 1'b0;
        end else if (accept && iter_req) begin
            work_hi <= '0;
            work_lo <= (opcode == OP_MUL) ? operand2 : operand1;
            work_b  <= (opcode == OP_MUL) ? operand1 : operand2;
            cnt     <= CNT_W'(WIDTH);
            is_mul  <= (opcode == OP_MUL);
        end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
            if (is_mul) begin
                work_hi <= {1'b0, mul_sum[WIDTH:1]};
                work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
            end else if (!div_trial[WIDTH+1]) begin
                work_hi <= div_trial[WIDTH:0];
                work_lo <= {work_lo[WIDTH-2:0], 1'b1};
            end else begin
                work_hi <= div_shift;
                work_lo <= {work_lo[WIDTH-2:0], 1'b0};
            end
        end
    end
`else
    assign iter_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            launch <= 1'b0;
        end else if (accept && !iter_req) begin
            op_q   <= opcode;
            a_q    <= operand1;
            b_q    <= operand2;
            launch <= 1'b1;
        end else begin
            launch <= 1'b0;
        end
    end

    always_comb begin
        sc_result  = '0;
        sc_rem     = '0;
        sc_carry   = 1'b0;
        sc_dz      = 1'b0;
        sc_illegal = 1'b0;
        case (op_q)
            OP_ADD:  {sc_carry, sc_result} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  {sc_carry, sc_result} = {1'b0, a_q} - {1'b0, b_q};
`ifdef ALU_MULDIV_EN
            OP_MUL:  sc_result = '0;
            OP_DIV: begin
                if (b_q == '0) begin
                    sc_result = '1;
                    sc_rem    = a_q;
                    sc_dz     = 1'b1;
                end
            end
`else
            OP_MUL:  sc_illegal = 1'b1;
            OP_DIV:  sc_illegal = 1'b1;
`endif
            OP_SHL:  sc_result = {a_q[WIDTH-2:0], 1'b0};
            OP_SHR:  sc_result = {1'b0, a_q[WIDTH-1:1]};
            OP_ROL:  sc_result = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
            OP_ROR:  sc_result = {a_q[0], a_q[WIDTH-1:1]};
            OP_AND:  sc_result = a_q & b_q;
            OP_OR:   sc_result = a_q | b_q;
            OP_XOR:  sc_result = a_q ^ b_q;
            OP_NOR:  sc_result = ~(a_q | b_q);
            OP_NAND: sc_result = ~(a_q & b_q);
            OP_XNOR: sc_result = ~(a_q ^ b_q);
            OP_GT:   sc_result = {{(WIDTH-1){1'b0}}, (a_q > b_q)};
            OP_EQ:   sc_result = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
            default: sc_result = '0;
        endcase
    end

    // select which result gets committed to the output registers this cycle
    always_comb begin
        load_out    = (state == IDLE) && launch;
        fin_result  = sc_result;
        fin_rem     = sc_rem;
        fin_carry   = sc_carry;
        fin_ovf     = 1'b0;
        fin_dz      = sc_dz;
        fin_illegal = sc_illegal;
`ifdef ALU_MULDIV_EN
        if ((state == BUSY) && (cnt == '0)) begin
            load_out    = 1'b1;
            fin_result  = work_lo;
            fin_rem     = is_mul ? '0 : work_hi[WIDTH-1:0];
            fin_carry   = 1'b0;
            fin_ovf     = is_mul && (work_hi[WIDTH-1:0] != '0);
            fin_dz      = 1'b0;
            fin_illegal = 1'b0;
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (launch)
                    state_next = DONE;
                else if (accept && iter_req)
                    state_next = BUSY;
            end
`ifdef ALU_MULDIV_EN
            BUSY:    if (cnt == '0) state_next = DONE;
`else
            BUSY:    state_next = IDLE;
`endif
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result       <= '0;
            remainder    <= '0;
            flag_zero    <= 1'b0;
            flag_neg     <= 1'b0;
            flag_carry   <= 1'b0;
            flag_ovf     <= 1'b0;
            flag_dz      <= 1'b0;
            flag_illegal <= 1'b0;
        end else if (load_out) begin
            result       <= fin_result;
            remainder    <= fin_rem;
            flag_zero    <= (fin_result == '0);
            flag_neg     <= fin_result[WIDTH-1];
            flag_carry   <= fin_carry;
            flag_ovf     <= fin_ovf;
            flag_dz      <= fin_dz;
            flag_illegal <= fin_illegal;
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu; expectations follow ALU_MULDIV_EN when it is defined.
module tb_seq_alu;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0, out_ready = 1'b0;
    logic             in_ready, out_valid;
    logic [3:0]       opcode = '0;
    logic [WIDTH-1:0] operand1 = '0, operand2 = '0;
    logic [WIDTH-1:0] result, remainder;
    logic             flag_zero, flag_neg, flag_carry, flag_ovf, flag_dz, flag_illegal;
    logic [5:0]       flags;

    int n_cmp = 0;
    int n_bad = 0;

    // flag order: zero, neg, carry, ovf, dz, illegal
    assign flags = {flag_zero, flag_neg, flag_carry, flag_ovf, flag_dz, flag_illegal};

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operand1(operand1), .operand2(operand2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .remainder(remainder), .flag_zero(flag_zero), .flag_neg(flag_neg),
        .flag_carry(flag_carry), .flag_ovf(flag_ovf), .flag_dz(flag_dz),
        .flag_illegal(flag_illegal)
    );

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] a, b, res;
        logic [5:0]       flg;
    } vec_t;

    task automatic apply_stimulus(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b);
        opcode = op; operand1 = a; operand2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit saw_ready);
        lat = 0;
        saw_ready = (in_ready === 1'b1);
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (in_ready === 1'b1) saw_ready = 1'b1;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_bad++; $display("[TB] FAIL reset_handshake got=%b want=00", {out_valid, in_ready});
        end
        n_cmp++;
        if ({result, remainder, flags} !== '0) begin
            n_bad++; $display("[TB] FAIL reset_outputs got=%h/%h/%b want=0", result, remainder, flags);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("[TB] FAIL reset_release_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_add_sub();
        int lat; bit sr;
        apply_stimulus(4'b0000, 16'hFFFF, 16'h0001);
        wait_done(lat, sr);
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("[TB] FAIL add_latency got=%0d want=1", lat); end
        n_cmp++;
        if ({result, flags} !== {16'h0000, 6'b101000}) begin
            n_bad++; $display("[TB] FAIL add_carry got=%h/%b want=0000/101000", result, flags);
        end
        release_out();
        apply_stimulus(4'b0001, 16'h0003, 16'h0005);
        wait_done(lat, sr);
        n_cmp++;
        if ({lat[7:0], result, remainder, flags} !== {8'd1, 16'hFFFE, 16'h0000, 6'b011000}) begin
            n_bad++; $display("[TB] FAIL sub_borrow got=%0d/%h/%h/%b want=1/fffe/0000/011000",
                              lat, result, remainder, flags);
        end
        release_out();
    endtask

    task automatic test_single_cycle_ops();
        vec_t vecs[$];
        int lat; bit sr;
        vecs.push_back('{4'b0100, 16'h8001, 16'h0000, 16'h0002, 6'b000000});
        vecs.push_back('{4'b0101, 16'h0001, 16'h0000, 16'h0000, 6'b100000});
        vecs.push_back('{4'b0111, 16'h0001, 16'h0000, 16'h8000, 6'b010000});
        vecs.push_back('{4'b1000, 16'hF0F0, 16'hFF00, 16'hF000, 6'b010000});
        vecs.push_back('{4'b1001, 16'h00F0, 16'h0F00, 16'h0FF0, 6'b000000});
        vecs.push_back('{4'b1010, 16'hF0F0, 16'hFF00, 16'h0FF0, 6'b000000});
        vecs.push_back('{4'b1011, 16'h0000, 16'h0000, 16'hFFFF, 6'b010000});
        vecs.push_back('{4'b1100, 16'hFFFF, 16'hFFFF, 16'h0000, 6'b100000});
        vecs.push_back('{4'b1101, 16'h1234, 16'h1234, 16'hFFFF, 6'b010000});
        vecs.push_back('{4'b1110, 16'h0005, 16'h0003, 16'h0001, 6'b000000});
        vecs.push_back('{4'b1110, 16'h0003, 16'h0005, 16'h0000, 6'b100000});
        vecs.push_back('{4'b1111, 16'h0007, 16'h0007, 16'h0001, 6'b000000});
        vecs.push_back('{4'b1111, 16'h0007, 16'h0008, 16'h0000, 6'b100000});
        vecs.push_back('{4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 6'b010000});
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, sr);
            n_cmp++;
            if ({lat[7:0], result, remainder, flags} !== {8'd1, vecs[i].res, 16'h0000, vecs[i].flg}) begin
                n_bad++;
                $display("[TB] FAIL op_vec%0d got=%0d/%h/%h/%b want=1/%h/0000/%b",
                         i, lat, result, remainder, flags, vecs[i].res, vecs[i].flg);
            end
            release_out();
        end
    endtask

    task automatic test_muldiv();
        int lat; bit sr;
`ifdef ALU_MULDIV_EN
        apply_stimulus(4'b0010, 16'd300, 16'd300);
        wait_done(lat, sr);
        n_cmp++;
        if (lat !== 17) begin n_bad++; $display("[TB] FAIL mul_latency got=%0d want=17", lat); end
        n_cmp++;
        if (sr !== 1'b0) begin n_bad++; $display("[TB] FAIL mul_ready_low got=%b want=0", sr); end
        n_cmp++;
        if ({result, remainder, flags} !== {16'h5F90, 16'h0000, 6'b000100}) begin
            n_bad++; $display("[TB] FAIL mul_ovf got=%h/%h/%b want=5f90/0000/000100", result, remainder, flags);
        end
        release_out();
        apply_stimulus(4'b0010, 16'h00FF, 16'h0002);
        wait_done(lat, sr);
        n_cmp++;
        if ({lat[7:0], result, flags} !== {8'd17, 16'h01FE, 6'b000000}) begin
            n_bad++; $display("[TB] FAIL mul_small got=%0d/%h/%b want=17/01fe/000000", lat, result, flags);
        end
        release_out();
        apply_stimulus(4'b0011, 16'd1000, 16'd7);
        wait_done(lat, sr);
        n_cmp++;
        if ({lat[7:0], result, remainder, flags} !== {8'd17, 16'd142, 16'd6, 6'b000000}) begin
            n_bad++; $display("[TB] FAIL div_basic got=%0d/%0d/%0d/%b want=17/142/6/000000",
                              lat, result, remainder, flags);
        end
        release_out();
        apply_stimulus(4'b0011, 16'd5, 16'd10);
        wait_done(lat, sr);
        n_cmp++;
        if ({lat[7:0], result, remainder, flags} !== {8'd17, 16'd0, 16'd5, 6'b100000}) begin
            n_bad++; $display("[TB] FAIL div_small got=%0d/%0d/%0d/%b want=17/0/5/100000",
                              lat, result, remainder, flags);
        end
        release_out();
        apply_stimulus(4'b0011, 16'h1234, 16'h0000);
        wait_done(lat, sr);
        n_cmp++;
        if ({lat[7:0], result, remainder, flags} !== {8'd1, 16'hFFFF, 16'h1234, 6'b010010}) begin
            n_bad++; $display("[TB] FAIL div_zero got=%0d/%h/%h/%b want=1/ffff/1234/010010",
                              lat, result, remainder, flags);
        end
        release_out();
`else
        apply_stimulus(4'b0010, 16'd5, 16'd5);
        wait_done(lat, sr);
        n_cmp++;
        if ({lat[7:0], result, remainder, flags} !== {8'd1, 16'h0000, 16'h0000, 6'b100001}) begin
            n_bad++; $display("[TB] FAIL mul_illegal got=%0d/%h/%h/%b want=1/0000/0000/100001",
                              lat, result, remainder, flags);
        end
        release_out();
        apply_stimulus(4'b0011, 16'd1000, 16'd7);
        wait_done(lat, sr);
        n_cmp++;
        if ({lat[7:0], result, remainder, flags} !== {8'd1, 16'h0000, 16'h0000, 6'b100001}) begin
            n_bad++; $display("[TB] FAIL div_illegal got=%0d/%h/%h/%b want=1/0000/0000/100001",
                              lat, result, remainder, flags);
        end
        release_out();
`endif
    endtask

    task automatic test_backpressure();
        int lat; bit sr;
        apply_stimulus(4'b0110, 16'h8001, 16'h0000);
        wait_done(lat, sr);
        n_cmp++;
        if ({lat[7:0], result} !== {8'd1, 16'h0003}) begin
            n_bad++; $display("[TB] FAIL rol_result got=%0d/%h want=1/0003", lat, result);
        end
        opcode = 4'b0000; operand1 = 16'h1111; operand2 = 16'h2222; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, in_ready, result} !== {2'b10, 16'h0003}) begin
                n_bad++; $display("[TB] FAIL hold_cycle%0d got=%b%b/%h want=10/0003",
                                  i, out_valid, in_ready, result);
            end
        end
        in_valid = 1'b0;
        release_out();
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++; $display("[TB] FAIL hold_release got=%b%b want=01", out_valid, in_ready);
        end
    endtask

    task automatic test_idle_out_ready();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++; $display("[TB] FAIL idle_out_ready got=%b%b want=01", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat; bit sr;
`ifdef ALU_MULDIV_EN
        apply_stimulus(4'b0010, 16'h00FF, 16'h0002);
        repeat (8) @(posedge clk);
`else
        apply_stimulus(4'b0110, 16'h8001, 16'h0000);
        repeat (3) @(posedge clk);
`endif
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_bad++; $display("[TB] FAIL midop_reset got=%b%b want=00", out_valid, in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++; $display("[TB] FAIL midop_release got=%b%b want=01", out_valid, in_ready);
        end
        @(posedge clk); #1;
        apply_stimulus(4'b0000, 16'd2, 16'd3);
        wait_done(lat, sr);
        n_cmp++;
        if ({lat[7:0], result, flags} !== {8'd1, 16'd5, 6'b000000}) begin
            n_bad++; $display("[TB] FAIL midop_add got=%0d/%h/%b want=1/0005/000000", lat, result, flags);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int lat; bit sr;
        apply_stimulus(4'b0000, 16'd1, 16'd1);
        wait_done(lat, sr);
        release_out();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("[TB] FAIL b2b_ready got=%b want=1", in_ready);
        end
        apply_stimulus(4'b0001, 16'd0, 16'd1);
        wait_done(lat, sr);
        n_cmp++;
        if ({lat[7:0], result, flags} !== {8'd1, 16'hFFFF, 6'b011000}) begin
            n_bad++; $display("[TB] FAIL b2b_sub got=%0d/%h/%b want=1/ffff/011000", lat, result, flags);
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_single_cycle_ops();
        test_muldiv();
        test_backpressure();
        test_idle_out_ready();
        test_reset_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end
endmodule
